decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised instruction decode stage between fetch and register-read/execute. Accepts one 32-bit instruction per cycle on a valid/ready handshake and produces fully decoded fields, control strobes and XLEN-wide immediate/jump target one cycle later. Optional skid buffer breaks the ready path. Adds illegal-opcode detection, flush and a decoded-instruction counter.

Parameters:
XLEN, 32, datapath width for out_imm, in_pc and out_jump_target; legal range is 32 or more.
SKID, 1, 1 = two-entry output (main + skid register) with registered in_ready; 0 = single register with combinational in_ready.
JUMP_PC_MODE, 0, 0 = out_jump_target = zero-extended instr[25:0]; 1 = {in_pc[XLEN-1:28], instr[25:0], 2'b00}.
CNT_W, 16, width of decoded_count.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
flush  in  1  drop all held/in-flight instructions
in_valid  in  1  instruction present
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  decoded bundle present
out_ready  in  1  consumer accepts
out_op  out  6  instr[31:26]
out_rs, out_rt, out_rd, out_shamt  out  5 each  register/shift fields
out_funct  out  6  instr[5:0]
out_aluop  out  2  ALU op
out_dest  out  5  write-back register
out_imm  out  XLEN  extended immediate
out_jump_target  out  XLEN  jump target
out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump, out_illegal  out  1 each  control strobes
decoded_count  out  CNT_W  completed out transfers

Behaviour:
- Reset (sync, rst=1 at clock edge): out_valid=0; all bundle outputs 0; skid empty; decoded_count=0; in_ready=1 in the first cycle after reset. rst has priority over flush and handshakes.
- Transfer in: in_valid & in_ready at edge. Transfer out: out_valid & out_ready at edge. Latency is 1 cycle from accepted input to out_valid.
- Decode by op. Fields not used by the class are driven 0, never X:
  - 000000 R-type: rs, rt, rd, shamt, funct valid; aluop = funct[3:2]; dest = rd; reg_we = 1.
  - 000001 beq: rs, rt valid; imm = sign-extended instr[15:0]; branch = 1.
  - 000010 and 000110 lw: rs, rt valid; imm = sign-extended; dest = rt; reg_we = 1; mem_re = 1.
  - 000011 sw: rs, rt valid; imm = sign-extended; mem_we = 1.
  - 000100 j: jump = 1; jump_target per JUMP_PC_MODE; rs and rt = 0.
  - 000101 lui: rt valid; dest = rt; reg_we = 1; imm = sign-extend({instr[15:0], 16'h0}) to XLEN.
  - Any other op: illegal = 1; all other strobes 0; out_op still carries the opcode.
- reg_we is forced 0 when dest == 0. dest remains visible.
- SKID=0: in_ready = !out_valid | out_ready, combinational.
- SKID=1: in_ready = skid empty, registered.
  - If an input is accepted while the output is held (out_valid & !out_ready), the new bundle goes to skid and in_ready drops the next cycle.
  - When the output transfers, skid moves to output in the same edge.
  - Order is strictly preserved.
- Output stability: while out_valid & !out_ready, every out_* bundle signal holds constant.
- Simultaneous in and out transfer with output full and skid empty: output loads the new bundle, skid stays empty, no bubble.
- Flush (rst=0): at the edge, out_valid=0, skid emptied, and any same-cycle input is discarded. decoded_count is not incremented even if out_ready=1. in_ready=1 the next cycle.
- decoded_count increments on each out transfer and wraps from 2^CNT_W-1 to 0.

Test Plan:
- R-type: in_instr=0x00221824 (rs=1, rt=2, rd=3, funct=0x24) -> next cycle out_valid=1, aluop=01, dest=3, reg_we=1, imm=0.
- lw with negative immediate: in_instr=0x0885FFFC -> rs=4, rt=5, dest=5, imm=0xFFFFFFFC, mem_re=1, reg_we=1. Repeat with op 000110 and rt=0 -> reg_we=0.
- lui and j: in_instr=0x14071234 -> imm=0x12340000, dest=7. With JUMP_PC_MODE=1, in_instr=0x10000100 and in_pc=0xA0000000 -> jump=1, target=0xA0000400.
- Illegal opcode: in_instr=0xFC000000 -> illegal=1, all other strobes 0, out_op=0x3F.
- Backpressure with SKID=1: stream I0..I3 with out_ready held 0 -> I0 held stable, I1 captured in skid, in_ready=0 from the following cycle. Release out_ready -> I0..I3 emerge in order, no loss or duplication, decoded_count=4.
- Flush and wrap: flush with output and skid both full -> out_valid=0 next cycle, count unchanged. With CNT_W=4, 17 transfers -> decoded_count=1. Reset asserted mid-stream -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction decode stage: valid/ready in, fully decoded bundle out one cycle later.
// Optional skid register decouples in_ready from out_ready.
module decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned SKID         = 1,
  parameter int unsigned JUMP_PC_MODE = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_op,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [1:0]        out_aluop,
  output logic [4:0]        out_dest,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_jump_target,
  output logic              out_reg_we,
  output logic              out_mem_re,
  output logic              out_mem_we,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  decoded_count
);

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [1:0]      aluop;
    logic [4:0]      dest;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jt;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t main_q;
  logic    main_v;
  logic    acc;
  logic    xfer;
  logic    unused_pc;

  // Low PC bits never reach the bundle; upper bits only in PC-relative jump mode.
  assign unused_pc = ^in_pc;

  always_comb begin
    dec    = '0;
    dec.op = in_instr[31:26];
    case (in_instr[31:26])
      6'h00: begin
        dec.rs     = in_instr[25:21];
        dec.rt     = in_instr[20:16];
        dec.rd     = in_instr[15:11];
        dec.shamt  = in_instr[10:6];
        dec.funct  = in_instr[5:0];
        dec.aluop  = in_instr[3:2];
        dec.dest   = in_instr[15:11];
        dec.reg_we = 1'b1;
      end
      6'h01: begin
        dec.rs     = in_instr[25:21];
        dec.rt     = in_instr[20:16];
        dec.imm    = XLEN'($signed(in_instr[15:0]));
        dec.branch = 1'b1;
      end
      6'h02, 6'h06: begin
        dec.rs     = in_instr[25:21];
        dec.rt     = in_instr[20:16];
        dec.imm    = XLEN'($signed(in_instr[15:0]));
        dec.dest   = in_instr[20:16];
        dec.reg_we = 1'b1;
        dec.mem_re = 1'b1;
      end
      6'h03: begin
        dec.rs     = in_instr[25:21];
        dec.rt     = in_instr[20:16];
        dec.imm    = XLEN'($signed(in_instr[15:0]));
        dec.mem_we = 1'b1;
      end
      6'h04: begin
        dec.jump = 1'b1;
        if (JUMP_PC_MODE != 0)
          dec.jt = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
        else
          dec.jt = XLEN'(in_instr[25:0]);
      end
      6'h05: begin
        dec.rt     = in_instr[20:16];
        dec.dest   = in_instr[20:16];
        dec.reg_we = 1'b1;
        dec.imm    = XLEN'($signed({in_instr[15:0], 16'h0000}));
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.dest == 5'd0)
      dec.reg_we = 1'b0;
  end

  assign acc  = in_valid & in_ready;
  assign xfer = main_v & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      bundle_t skid_q;
      logic    skid_v;

      assign in_ready = !skid_v;

      // Skid only fills while main is held, so it always drains into main first.
      always_ff @(posedge clk) begin
        if (rst) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
          main_q <= '0;
          skid_q <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end else if (!main_v || out_ready) begin
          if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= 1'b0;
          end else begin
            main_v <= acc;
            if (acc)
              main_q <= dec;
          end
        end else if (acc) begin
          skid_q <= dec;
          skid_v <= 1'b1;
        end
      end
    end else begin : g_direct
      assign in_ready = !main_v || out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_v <= 1'b0;
          main_q <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
        end else if (in_ready) begin
          main_v <= acc;
          if (acc)
            main_q <= dec;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      decoded_count <= '0;
    else if (!flush && xfer)
      decoded_count <= decoded_count + CNT_W'(1);
  end

  assign out_valid       = main_v;
  assign out_op          = main_q.op;
  assign out_rs          = main_q.rs;
  assign out_rt          = main_q.rt;
  assign out_rd          = main_q.rd;
  assign out_shamt       = main_q.shamt;
  assign out_funct       = main_q.funct;
  assign out_aluop       = main_q.aluop;
  assign out_dest        = main_q.dest;
  assign out_imm         = main_q.imm;
  assign out_jump_target = main_q.jt;
  assign out_reg_we      = main_q.reg_we;
  assign out_mem_re      = main_q.mem_re;
  assign out_mem_we      = main_q.mem_we;
  assign out_branch      = main_q.branch;
  assign out_jump        = main_q.jump;
  assign out_illegal     = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: fixed decode vectors, handshake corner sequences and a
// randomized run checked against an in-order scoreboard fed by a behavioural decoder.
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] jt;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt, out_dest;
  logic [1:0]  out_aluop;
  logic [31:0] out_imm, out_jump_target;
  logic        out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump, out_illegal;
  logic [3:0]  decoded_count;

  int   n_vec  = 0;
  int   n_fail = 0;
  logic armed  = 1'b0;
  exp_t act;
  exp_t q[$];
  logic [3:0] mcount = '0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1), .JUMP_PC_MODE(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_funct(out_funct), .out_aluop(out_aluop), .out_dest(out_dest), .out_imm(out_imm),
    .out_jump_target(out_jump_target), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
    .out_mem_we(out_mem_we), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal), .decoded_count(decoded_count)
  );

  always_comb begin
    act         = '0;
    act.op      = out_op;
    act.rs      = out_rs;
    act.rt      = out_rt;
    act.rd      = out_rd;
    act.shamt   = out_shamt;
    act.funct   = out_funct;
    act.aluop   = out_aluop;
    act.dest    = out_dest;
    act.imm     = out_imm;
    act.jt      = out_jump_target;
    act.reg_we  = out_reg_we;
    act.mem_re  = out_mem_re;
    act.mem_we  = out_mem_we;
    act.branch  = out_branch;
    act.jump    = out_jump;
    act.illegal = out_illegal;
  end

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Behavioural decoder: instruction class first, then fields by shift/mask arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int unsigned op;
    logic is_r, is_beq, is_lw, is_sw, is_j, is_lui;
    logic [31:0] sx;
    e      = '0;
    op     = ins >> 26;
    is_r   = (op == 0);
    is_beq = (op == 1);
    is_lw  = (op == 2) || (op == 6);
    is_sw  = (op == 3);
    is_j   = (op == 4);
    is_lui = (op == 5);
    sx     = (ins & 32'hFFFF) - ((ins & 32'h8000) << 1);
    e.op   = 6'(op);
    if (is_r || is_beq || is_lw || is_sw) e.rs = 5'((ins >> 21) & 31);
    if (is_r || is_beq || is_lw || is_sw || is_lui) e.rt = 5'((ins >> 16) & 31);
    if (is_r) begin
      e.rd    = 5'((ins >> 11) & 31);
      e.shamt = 5'((ins >> 6) & 31);
      e.funct = 6'(ins & 63);
      e.aluop = 2'((ins >> 2) & 3);
      e.dest  = e.rd;
    end
    if (is_lw || is_lui) e.dest = e.rt;
    if (is_beq || is_lw || is_sw) e.imm = sx;
    if (is_lui) e.imm = ins << 16;
    if (is_j) e.jt = (pc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    e.reg_we  = (is_r || is_lw || is_lui) && (e.dest != 0);
    e.mem_re  = is_lw;
    e.mem_we  = is_sw;
    e.branch  = is_beq;
    e.jump    = is_j;
    e.illegal = (op > 6);
    return e;
  endfunction

  function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [1:0] alu, input logic [4:0] dest, input logic [31:0] imm,
                              input logic [31:0] jt, input logic [5:0] ctrl);
    exp_t e;
    e = '{op, rs, rt, rd, sh, fn, alu, dest, imm, jt,
          ctrl[5], ctrl[4], ctrl[3], ctrl[2], ctrl[1], ctrl[0]};
    return e;
  endfunction

  // Scoreboard: occupancy of the queue is the number of held bundles (main + skid).
  always @(negedge clk) begin
    if (armed) begin
      chk("occupancy", {out_valid, in_ready}, {q.size() > 0, q.size() < 2});
      chk("count", decoded_count, mcount);
      if (q.size() > 0) chk("order", act, q[0]);
      if (rst) begin
        q.delete();
        mcount = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          mcount = mcount + 4'd1;
        end
        if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
    return {op, 26'($urandom)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t        tbl[13];
  logic [31:0] bp[4];
  int          idx;
  logic        took;
  logic [3:0]  cnt0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    tbl[0]  = '{32'h0022_1824, 32'h0, mk(6'h00, 1, 2, 3, 0, 6'h24, 2'b01, 3, 32'h0, 32'h0, 6'b100000)};
    tbl[1]  = '{32'h0885_FFFC, 32'h0, mk(6'h02, 4, 5, 0, 0, 0, 0, 5, 32'hFFFF_FFFC, 32'h0, 6'b110000)};
    tbl[2]  = '{32'h1880_0010, 32'h0, mk(6'h06, 4, 0, 0, 0, 0, 0, 0, 32'h10, 32'h0, 6'b010000)};
    tbl[3]  = '{32'h1407_1234, 32'h0, mk(6'h05, 0, 7, 0, 0, 0, 0, 7, 32'h1234_0000, 32'h0, 6'b100000)};
    tbl[4]  = '{32'h1000_0100, 32'hA000_0000, mk(6'h04, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hA000_0400, 6'b000010)};
    tbl[5]  = '{32'hFC00_0000, 32'h0, mk(6'h3F, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000001)};
    tbl[6]  = '{32'h04A6_8000, 32'h0, mk(6'h01, 5, 6, 0, 0, 0, 0, 0, 32'hFFFF_8000, 32'h0, 6'b000100)};
    tbl[7]  = '{32'h0C43_0004, 32'h0, mk(6'h03, 2, 3, 0, 0, 0, 0, 0, 32'h4, 32'h0, 6'b001000)};
    tbl[8]  = '{32'h0043_0020, 32'h0, mk(6'h00, 2, 3, 0, 0, 6'h20, 2'b00, 0, 32'h0, 32'h0, 6'b000000)};
    tbl[9]  = '{32'h1402_8001, 32'h0, mk(6'h05, 0, 2, 0, 0, 0, 0, 2, 32'h8001_0000, 32'h0, 6'b100000)};
    tbl[10] = '{32'h13FF_FFFF, 32'h5ABC_DEF0, mk(6'h04, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h5FFF_FFFC, 6'b000010)};
    tbl[11] = '{32'h000A_2080, 32'h0, mk(6'h00, 0, 10, 4, 2, 0, 0, 4, 32'h0, 32'h0, 6'b100000)};
    tbl[12] = '{32'h1FFF_FFFF, 32'h0, mk(6'h07, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000001)};
    for (int k = 0; k < 4; k++) bp[k] = 32'h0800_0000 | ((k + 1) << 16) | k;

    repeat (2) @(posedge clk);
    #1 armed = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bundle", act, '0);
    chk("rst_count", decoded_count, 4'd0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;

    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_valid = 1'b1; in_instr = tbl[i].instr; in_pc = tbl[i].pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d", i), act, tbl[i].e);
      @(posedge clk); #1;
    end

    // Backpressure: I0 held, I1 in skid, then drain in order.
    do_reset();
    out_ready = 1'b0; in_pc = '0;
    in_valid = 1'b1; in_instr = bp[0];
    @(posedge clk); #1;
    in_instr = bp[1];
    @(posedge clk); #1;
    chk("bp_ready_low", in_ready, 1'b0);
    chk("bp_hold", act, model(bp[0], 32'h0));
    in_instr = bp[2];
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable", act, model(bp[0], 32'h0));
    chk("bp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1; idx = 2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) idx++;
      in_valid = (idx < 4);
      if (idx < 4) in_instr = bp[idx];
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_count", decoded_count, 4'd4);
    chk("bp_drained", out_valid, 1'b0);

    // Flush with main and skid both full, out_ready high, and a same-cycle input.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = bp[0];
    @(posedge clk); #1;
    in_instr = bp[1];
    @(posedge clk); #1;
    chk("fl_full", in_ready, 1'b0);
    cnt0 = decoded_count;
    out_ready = 1'b1; flush = 1'b1; in_instr = bp[2];
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_count", decoded_count, cnt0);
    chk("fl_ready", in_ready, 1'b1);

    // Counter wrap: 17 transfers on a 4-bit counter.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_instr = rand_instr(); in_pc = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wrap", decoded_count, 4'd1);

    // Reset in the middle of a stream with both registers full.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = rand_instr(); in_pc = $urandom;
      out_ready = (k == 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_bundle", act, '0);
    chk("mid_rst_count", decoded_count, 4'd0);
    chk("mid_rst_ready", in_ready, 1'b1);

    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("final_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
